// File: rtl/bht_update_queue_if.sv
// Bus bundle between the branch-prediction frontend/backend and the BHT update queue.
// slave is the queue's view; master is the view of the surrounding pipeline.
interface bht_update_queue_if #(
   parameter int unsigned bht_idx_width_p = 8,
   parameter int unsigned ghist_width_p   = 12
);
   logic                       init_done_i;
   logic                       p_v_i;
   logic [bht_idx_width_p-1:0] p_idx_i;
   logic [ghist_width_p-1:0]   p_ghist_i;
   logic                       p_taken_i;
   logic                       p_ready_o;
   logic                       r_v_i;
   logic                       r_taken_i;
   logic                       r_ready_o;
   logic                       flush_i;
   logic                       w_v_o;
   logic [bht_idx_width_p-1:0] w_idx_o;
   logic [ghist_width_p-1:0]   w_ghist_o;
   logic                       w_taken_o;
   logic                       correct_o;
   logic                       w_yumi_i;
   logic                       mispredict_o;
   logic [15:0]                miss_cnt_o;

   modport slave (
      input  init_done_i, p_v_i, p_idx_i, p_ghist_i, p_taken_i,
      input  r_v_i, r_taken_i, flush_i, w_yumi_i,
      output p_ready_o, r_ready_o, w_v_o, w_idx_o, w_ghist_o, w_taken_o,
      output correct_o, mispredict_o, miss_cnt_o
   );

   modport master (
      output init_done_i, p_v_i, p_idx_i, p_ghist_i, p_taken_i,
      output r_v_i, r_taken_i, flush_i, w_yumi_i,
      input  p_ready_o, r_ready_o, w_v_o, w_idx_o, w_ghist_o, w_taken_o,
      input  correct_o, mispredict_o, miss_cnt_o
   );
endinterface

// File: rtl/bht_update_queue.sv
// In-flight branch prediction tracker: enqueue at issue, resolve in order, then
// present resolved entries to the tournament BHT write port under valid/yumi.
module bht_update_queue #(
   parameter int unsigned bht_idx_width_p = 8,
   parameter int unsigned ghist_width_p   = 12,
   parameter int unsigned depth_p         = 8
) (
   input logic               clk_i,
   input logic               reset_i,
   bht_update_queue_if.slave bus
);
   localparam int unsigned AW = $clog2(depth_p);
   localparam int unsigned PW = AW + 1;

   typedef struct packed {
      logic [bht_idx_width_p-1:0] idx;
      logic [ghist_width_p-1:0]   ghist;
      logic                       pred;
      logic                       taken;
      logic                       correct;
   } entry_t;

   typedef enum logic [0:0] {INIT = 1'b0, RUN = 1'b1} state_e;

   state_e        state_q, state_d;
   logic [PW-1:0] head_q, res_q, tail_q;
   logic [PW-1:0] head_d, res_d, tail_d;
   entry_t        mem_q [depth_p];
   logic          mispredict_q;
   logic [15:0]   miss_cnt_q;

   logic          run;
   logic          p_ready;
   logic          r_ready;
   logic          w_v;
   logic          enq;
   logic          rsv;
   logic          upd;
   logic          miss;
   logic [AW-1:0] head_slot;
   logic [AW-1:0] res_slot;
   logic [AW-1:0] tail_slot;

   assign head_slot = head_q[AW-1:0];
   assign res_slot  = res_q[AW-1:0];
   assign tail_slot = tail_q[AW-1:0];

   // Handshake qualifiers, all derived from registered state only
   assign run     = (state_q == RUN);
   assign p_ready = run && ((tail_q - head_q) < PW'(depth_p));
   assign r_ready = (res_q != tail_q);
   assign w_v     = run && (head_q != res_q);

   assign enq  = bus.p_v_i && p_ready && !bus.flush_i;
   assign rsv  = bus.r_v_i && r_ready;
   assign upd  = bus.w_yumi_i && w_v;
   assign miss = rsv && (mem_q[res_slot].pred != bus.r_taken_i);

   // Next-state: INIT waits for table init, RUN is terminal until reset
   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      res_d   = res_q;
      tail_d  = tail_q;
      case (state_q)
         INIT:    if (bus.init_done_i) state_d = RUN;
         RUN:     state_d = RUN;
         default: state_d = INIT;
      endcase
      if (upd) head_d = head_q + PW'(1);
      if (rsv) res_d  = res_q + PW'(1);
      if (bus.flush_i)  tail_d = res_d;
      else if (enq)     tail_d = tail_q + PW'(1);
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q <= INIT;
         head_q  <= '0;
         res_q   <= '0;
         tail_q  <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         res_q   <= res_d;
         tail_q  <= tail_d;
      end
   end

   // Enqueue and resolve never hit the head slot while it is being presented
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         for (int unsigned i = 0; i < depth_p; i++) mem_q[i] <= '0;
      end else begin
         if (enq) begin
            mem_q[tail_slot].idx   <= bus.p_idx_i;
            mem_q[tail_slot].ghist <= bus.p_ghist_i;
            mem_q[tail_slot].pred  <= bus.p_taken_i;
         end
         if (rsv) begin
            mem_q[res_slot].taken   <= bus.r_taken_i;
            mem_q[res_slot].correct <= (mem_q[res_slot].pred == bus.r_taken_i);
         end
      end
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         mispredict_q <= 1'b0;
         miss_cnt_q   <= '0;
      end else begin
         mispredict_q <= miss;
         if (miss && (miss_cnt_q != 16'hFFFF)) miss_cnt_q <= miss_cnt_q + 16'd1;
      end
   end

   assign bus.p_ready_o    = p_ready;
   assign bus.r_ready_o    = r_ready;
   assign bus.w_v_o        = w_v;
   assign bus.w_idx_o      = mem_q[head_slot].idx;
   assign bus.w_ghist_o    = mem_q[head_slot].ghist;
   assign bus.w_taken_o    = mem_q[head_slot].taken;
   assign bus.correct_o    = mem_q[head_slot].correct;
   assign bus.mispredict_o = mispredict_q;
   assign bus.miss_cnt_o   = miss_cnt_q;
endmodule

// File: tb/tb_bht_update_queue.sv
// Bench for bht_update_queue: directed scenarios plus random traffic, all checked
// against a queue-based reference model of in-flight and resolved predictions.
module tb_bht_update_queue;
   localparam int unsigned IW    = 8;
   localparam int unsigned GW    = 12;
   localparam int unsigned DEPTH = 8;

   logic clk = 1'b0;
   logic reset_i;
   always #5 clk = ~clk;

   bht_update_queue_if #(.bht_idx_width_p(IW), .ghist_width_p(GW)) bus ();

   bht_update_queue #(
      .bht_idx_width_p(IW),
      .ghist_width_p  (GW),
      .depth_p        (DEPTH)
   ) dut (
      .clk_i  (clk),
      .reset_i(reset_i),
      .bus    (bus)
   );

   typedef struct {
      logic [IW-1:0] idx;
      logic [GW-1:0] ghist;
      logic          pred;
      logic          taken;
   } ent_t;

   ent_t        pend[$];
   ent_t        done[$];
   bit          m_run;
   bit          m_misp;
   int unsigned m_cnt;
   int          errors = 0;
   int          checks = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      pend.delete();
      done.delete();
      m_run  = 1'b0;
      m_misp = 1'b0;
      m_cnt  = 0;
   endtask

   task automatic idle();
      bus.p_v_i     = 1'b0;
      bus.p_idx_i   = '0;
      bus.p_ghist_i = '0;
      bus.p_taken_i = 1'b0;
      bus.r_v_i     = 1'b0;
      bus.r_taken_i = 1'b0;
      bus.flush_i   = 1'b0;
      bus.w_yumi_i  = 1'b0;
   endtask

   task automatic rand_pred();
      bus.p_idx_i   = IW'($urandom);
      bus.p_ghist_i = GW'($urandom);
      bus.p_taken_i = 1'($urandom);
   endtask

   // Check outputs at negedge against the model, then advance the model with the
   // inputs the DUT samples at the coming posedge.
   task automatic cycle();
      ent_t e;
      bit pr, rr, wv;
      @(negedge clk);
      pr = m_run && ((pend.size() + done.size()) < DEPTH);
      rr = (pend.size() != 0);
      wv = m_run && (done.size() != 0);
      chk("p_ready", 32'(bus.p_ready_o), 32'(pr));
      chk("r_ready", 32'(bus.r_ready_o), 32'(rr));
      chk("w_v", 32'(bus.w_v_o), 32'(wv));
      if (wv) begin
         e = done[0];
         chk("w_idx", 32'(bus.w_idx_o), 32'(e.idx));
         chk("w_ghist", 32'(bus.w_ghist_o), 32'(e.ghist));
         chk("w_taken", 32'(bus.w_taken_o), 32'(e.taken));
         chk("correct", 32'(bus.correct_o), 32'(e.pred == e.taken));
      end
      chk("mispredict", 32'(bus.mispredict_o), 32'(m_misp));
      chk("miss_cnt", 32'(bus.miss_cnt_o), m_cnt);
      m_misp = 1'b0;
      if (wv && bus.w_yumi_i) void'(done.pop_front());
      if (bus.r_v_i && rr) begin
         e = pend.pop_front();
         e.taken = bus.r_taken_i;
         done.push_back(e);
         if (e.pred != e.taken) begin
            m_misp = 1'b1;
            if (m_cnt < 32'hFFFF) m_cnt++;
         end
      end
      if (bus.flush_i) pend.delete();
      else if (bus.p_v_i && pr) begin
         e.idx   = bus.p_idx_i;
         e.ghist = bus.p_ghist_i;
         e.pred  = bus.p_taken_i;
         e.taken = 1'b0;
         pend.push_back(e);
      end
      if (!m_run && bus.init_done_i) m_run = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [IW-1:0] saved_idx;
      int            n_upd;

      idle();
      bus.init_done_i = 1'b0;
      reset_i = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_p_ready", 32'(bus.p_ready_o), 0);
      chk("rst_r_ready", 32'(bus.r_ready_o), 0);
      chk("rst_w_v", 32'(bus.w_v_o), 0);
      chk("rst_mispredict", 32'(bus.mispredict_o), 0);
      chk("rst_miss_cnt", 32'(bus.miss_cnt_o), 0);
      chk("rst_w_idx", 32'(bus.w_idx_o), 0);
      chk("rst_w_ghist", 32'(bus.w_ghist_o), 0);
      chk("rst_w_taken", 32'(bus.w_taken_o), 0);
      chk("rst_correct", 32'(bus.correct_o), 0);

      // Init hold-off
      reset_i = 1'b1;
      repeat (5) cycle();
      bus.init_done_i = 1'b1;
      cycle();
      bus.init_done_i = 1'b0;
      chk("init_ready", 32'(bus.p_ready_o), 1);
      cycle();

      // Correct prediction
      bus.p_v_i = 1'b1; bus.p_idx_i = 8'h3A; bus.p_ghist_i = 12'h5C1; bus.p_taken_i = 1'b1;
      cycle();
      bus.p_v_i = 1'b0;
      bus.r_v_i = 1'b1; bus.r_taken_i = 1'b1;
      cycle();
      bus.r_v_i = 1'b0;
      chk("cp_w_v", 32'(bus.w_v_o), 1);
      chk("cp_w_idx", 32'(bus.w_idx_o), 32'h3A);
      chk("cp_w_ghist", 32'(bus.w_ghist_o), 32'h5C1);
      chk("cp_correct", 32'(bus.correct_o), 1);
      chk("cp_mispredict", 32'(bus.mispredict_o), 0);
      bus.w_yumi_i = 1'b1;
      cycle();
      bus.w_yumi_i = 1'b0;

      // Mispredict
      rand_pred();
      bus.p_v_i = 1'b1; bus.p_taken_i = 1'b0;
      cycle();
      bus.p_v_i = 1'b0;
      bus.r_v_i = 1'b1; bus.r_taken_i = 1'b1;
      cycle();
      bus.r_v_i = 1'b0;
      chk("mp_pulse", 32'(bus.mispredict_o), 1);
      chk("mp_correct", 32'(bus.correct_o), 0);
      chk("mp_cnt", 32'(bus.miss_cnt_o), 1);
      bus.w_yumi_i = 1'b1;
      cycle();
      bus.w_yumi_i = 1'b0;
      chk("mp_pulse_end", 32'(bus.mispredict_o), 0);

      // Full and backpressure
      bus.p_v_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         rand_pred();
         cycle();
      end
      bus.p_v_i = 1'b0;
      bus.r_v_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         bus.r_taken_i = 1'($urandom);
         cycle();
      end
      bus.r_v_i = 1'b0;
      cycle();
      chk("full_p_ready", 32'(bus.p_ready_o), 0);
      saved_idx = done[0].idx;
      repeat (3) cycle();
      chk("hold_w_idx", 32'(bus.w_idx_o), 32'(saved_idx));
      bus.w_yumi_i = 1'b1;
      cycle();
      bus.w_yumi_i = 1'b0;
      chk("freed_p_ready", 32'(bus.p_ready_o), 1);
      chk("next_w_idx", 32'(bus.w_idx_o), 32'(done[0].idx));
      bus.w_yumi_i = 1'b1;
      repeat (7) cycle();
      bus.w_yumi_i = 1'b0;
      chk("drained_w_v", 32'(bus.w_v_o), 0);

      // Flush with simultaneous resolve and enqueue
      bus.p_v_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         rand_pred();
         cycle();
      end
      bus.p_v_i = 1'b0;
      bus.r_v_i = 1'b1;
      repeat (2) begin
         bus.r_taken_i = 1'($urandom);
         cycle();
      end
      bus.flush_i = 1'b1; bus.r_taken_i = 1'b0;
      bus.p_v_i = 1'b1; bus.p_idx_i = 8'hEE; bus.p_ghist_i = 12'hEEE;
      cycle();
      idle();
      chk("flush_r_ready", 32'(bus.r_ready_o), 0);
      n_upd = 0;
      bus.w_yumi_i = 1'b1;
      for (int i = 0; i < 12; i++) begin
         if (bus.w_v_o) begin
            n_upd++;
            chk("flush_not_squashed_idx", 32'(bus.w_idx_o != 8'hEE || bus.w_ghist_o != 12'hEEE), 1);
         end
         cycle();
      end
      bus.w_yumi_i = 1'b0;
      chk("flush_updates", 32'(n_upd), 3);
      chk("flush_r_ready_after", 32'(bus.r_ready_o), 0);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         rand_pred();
         bus.p_v_i     = 1'($urandom);
         bus.r_v_i     = 1'($urandom);
         bus.r_taken_i = 1'($urandom);
         bus.w_yumi_i  = ($urandom_range(0, 3) != 0);
         bus.flush_i   = ($urandom_range(0, 19) == 0);
         cycle();
      end
      idle();
      bus.r_v_i = 1'b1; bus.w_yumi_i = 1'b1;
      repeat (12) cycle();
      idle();
      cycle();

      // Async reset with pending updates
      bus.p_v_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         rand_pred();
         cycle();
      end
      bus.p_v_i = 1'b0;
      bus.r_v_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.r_taken_i = 1'($urandom);
         cycle();
      end
      bus.r_v_i = 1'b0;
      chk("pre_reset_w_v", 32'(bus.w_v_o), 1);
      #2;
      reset_i = 1'b0;
      #1;
      chk("async_w_v", 32'(bus.w_v_o), 0);
      model_reset();
      repeat (2) cycle();
      reset_i = 1'b1;
      bus.init_done_i = 1'b1;
      repeat (3) cycle();
      chk("post_reset_w_v", 32'(bus.w_v_o), 0);
      rand_pred();
      bus.p_v_i = 1'b1;
      cycle();
      bus.p_v_i = 1'b0;
      bus.r_v_i = 1'b1; bus.r_taken_i = 1'($urandom);
      cycle();
      bus.r_v_i = 1'b0;
      chk("new_resolve_w_v", 32'(bus.w_v_o), 1);
      bus.w_yumi_i = 1'b1;
      cycle();
      idle();

      // Mispredict counter saturation: one wrong prediction resolved per cycle
      bus.p_v_i = 1'b1; bus.r_v_i = 1'b1; bus.r_taken_i = 1'b1; bus.w_yumi_i = 1'b1;
      for (int i = 0; i < 70000 && m_cnt != 32'hFFFF; i++) begin
         bus.p_idx_i = IW'($urandom); bus.p_ghist_i = GW'($urandom); bus.p_taken_i = 1'b0;
         cycle();
      end
      chk("sat_reached", 32'(bus.miss_cnt_o), 32'hFFFF);
      repeat (3) cycle();
      chk("sat_held", 32'(bus.miss_cnt_o), 32'hFFFF);
      chk("sat_pulse", 32'(bus.mispredict_o), 1);
      idle();
      repeat (4) cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/bht_update_queue.md
# bht_update_queue

Tracks every in-flight branch prediction from issue to resolution and drives the write/update side of the tournament branch history table. The frontend enqueues each prediction (index, global-history snapshot, predicted direction). The backend resolves branches in program order. The queue computes correctness and presents `w_v_o`/`w_idx_o`/`correct_o` to the predictor under a valid/yumi handshake. It also supports squashing wrong-path predictions on redirect.

## Interface
- `bht_idx_width_p`, 8, BHT index width
- `ghist_width_p`, 12, global-history snapshot width
- `depth_p`, 8, queue entries (power of 2, ≥2)
- `clk_i`  in  1  clock, rising edge
- `reset_i`  in  1  reset, asynchronous, active-low
- `init_done_i`  in  1  predictor table initialisation complete
- `p_v_i`  in  1  prediction issued, enqueue request
- `p_idx_i`  in  `bht_idx_width_p`  BHT index of the prediction
- `p_ghist_i`  in  `ghist_width_p`  global history used for the prediction
- `p_taken_i`  in  1  predicted direction
- `p_ready_o`  out  1  enqueue accepted this cycle if `p_v_i`
- `r_v_i`  in  1  oldest unresolved branch resolves
- `r_taken_i`  in  1  actual direction
- `r_ready_o`  out  1  at least one unresolved entry exists
- `flush_i`  in  1  squash all unresolved entries
- `w_v_o`  out  1  update request to predictor
- `w_idx_o`  out  `bht_idx_width_p`  update index
- `w_ghist_o`  out  `ghist_width_p`  update history snapshot
- `w_taken_o`  out  1  actual direction
- `correct_o`  out  1  prediction matched outcome
- `w_yumi_i`  in  1  predictor consumed the update
- `mispredict_o`  out  1  one-cycle pulse on a wrong prediction
- `miss_cnt_o`  out  16  saturating mispredict count

## Operation
- Circular buffer with three pointers, each log2(`depth_p`)+1 bits and wrapping modulo 2·`depth_p`:
  - `head`: oldest entry, next to write to the predictor.
  - `res`: next entry to resolve.
  - `tail`: next free slot.
- Entries in [`head`,`res`) are resolved and await update. Entries in [`res`,`tail`) are unresolved.
- FSM states:
  - `INIT`: entered on reset. `p_ready_o`=0, `w_v_o`=0. Moves to `RUN` on the first cycle that samples `init_done_i`=1.
  - `RUN`: normal operation. `init_done_i` is ignored once in `RUN`.
- Enqueue: when `p_v_i && p_ready_o && !flush_i`, store {idx, ghist, pred} at `tail` and advance `tail`.
  - `p_ready_o` = `RUN` && (`tail`−`head`) < `depth_p`.
- Resolve: when `r_v_i && r_ready_o`, store `r_taken_i` at `res`, set correct = (pred == `r_taken_i`), and advance `res`. If `r_ready_o`=0, `r_v_i` is ignored.
- Update: `w_v_o` = `RUN` && `head`≠`res`. Outputs come from the entry at `head`.
  - On `w_yumi_i && w_v_o`, `head` advances.
  - While `w_v_o`=1 and `w_yumi_i`=0, all `w_*` outputs and `correct_o` hold stable.
  - `w_yumi_i` while `w_v_o`=0 is ignored.
- Flush: `tail` ← `res` (after any same-cycle resolve). Resolved entries are kept and still written.
- Mispredict: when a resolve is incorrect, `mispredict_o`=1 for the next cycle, and `miss_cnt_o` increments in that same cycle, saturating at 0xFFFF.

## Timing
- Reset values:
  - All pointers 0, state `INIT`.
  - `p_ready_o`, `r_ready_o`, `w_v_o`, `mispredict_o` = 0; `miss_cnt_o` = 0.
  - `w_idx_o`, `w_ghist_o`, `w_taken_o`, `correct_o` = 0.
- Reset mid-operation discards all entries, and no update is emitted afterward.
- Latencies:
  - Enqueue at cycle t → `r_ready_o`=1 at t+1 (earliest resolve).
  - Resolve at t → `w_v_o`=1 at t+1. No same-cycle bypass.
  - Back-to-back updates: with `w_yumi_i` high every cycle, one update per cycle.
- Full: a slot freed by `w_yumi_i` at t makes `p_ready_o`=1 at t+1, not at t (no pass-through).
- Simultaneous events:
  - Enqueue, resolve and yumi in the same cycle are all performed.
  - Flush with `r_v_i`: the resolve completes and the rest is squashed.
  - Flush with `p_v_i`: the enqueue is discarded.
- All outputs are registered or derived only from registered state. There is no combinational path from any input to any output.

## Test plan
- **Reset/init:** hold `init_done_i`=0 for 5 cycles after reset release → `p_ready_o`=0 throughout; raise it → `p_ready_o`=1 next cycle.
- **Correct prediction:** enqueue idx=0x3A, ghist=0x5C1, pred=1; resolve taken=1 → next cycle `w_v_o`=1, `w_idx_o`=0x3A, `w_ghist_o`=0x5C1, `correct_o`=1, `mispredict_o`=0.
- **Mispredict and saturation:** pred=0, resolve taken=1 → `mispredict_o` pulses for 1 cycle, `correct_o`=0, `miss_cnt_o`=1. Preload count to 0xFFFF and mispredict again → stays 0xFFFF.
- **Full/backpressure:** enqueue 8 entries, resolve all, hold `w_yumi_i`=0 → `p_ready_o`=0 and `w_*` stable. Assert yumi for 1 cycle → `p_ready_o`=1 the following cycle and the next entry is presented.
- **Flush:** enqueue 5, resolve 2, assert `flush_i` together with `r_v_i` and `p_v_i` → exactly 3 updates are emitted, `r_ready_o`=0, and the enqueued entry is absent.
- **Async reset mid-stream:** drop `reset_i` with 4 entries pending → `w_v_o`=0 immediately and remains 0 after release until a new resolve occurs.
